// File: rtl/memory_pkg.sv
// Latency selector constants shared by every dual_port_memory instance.
package memory_pkg;

    localparam string LOW_LATENCY  = "LOW_LATENCY";
    localparam string HIGH_LATENCY = "HIGH_LATENCY";

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port synchronous RAM: one write port, one read port, one clock.
// Read-first, registered read, optional output register for block RAM inference.
module dual_port_memory
    import memory_pkg::*;
#(
    parameter int    MEMORY_WIDTH   = 32,
    parameter int    MEMORY_DEPTH   = 512,
    parameter string MEMORY_LATENCY = "LOW_LATENCY",
    localparam int   ADDR_W         = $clog2(MEMORY_DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [ADDR_W-1:0]       WRITE_ADDRESS,
    input  logic [MEMORY_WIDTH-1:0] DATA_IN,
    input  logic                    WRITE_ENABLE,
    input  logic [ADDR_W-1:0]       READ_ADDRESS,
    input  logic                    READ_ENBLE,
    output logic [MEMORY_WIDTH-1:0] DATA_OUT
);

    // One extra bit so the depth itself is representable for the range compare.
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(MEMORY_DEPTH);

    logic [MEMORY_WIDTH-1:0] r_mem [MEMORY_DEPTH] = '{default: '0};
    logic [MEMORY_WIDTH-1:0] r_rd_q;
    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic [MEMORY_WIDTH-1:0] w_rd_data;

    // Address range decode and read mux; out-of-range reads return zero.
    always_comb begin
        w_wr_in_range = ({1'b0, WRITE_ADDRESS} < C_DEPTH);
        w_rd_in_range = ({1'b0, READ_ADDRESS} < C_DEPTH);
        w_rd_data     = '0;
        if (w_rd_in_range) begin
            w_rd_data = r_mem[READ_ADDRESS];
        end
    end

    // Array write; blocked while reset is held, array contents are never cleared.
    always_ff @(posedge CLK) begin
        if (WRITE_ENABLE && RST_N && w_wr_in_range) begin
            r_mem[WRITE_ADDRESS] <= DATA_IN;
        end
    end

    // Read stage 1: samples old contents on a same-edge write (read-first).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_q <= '0;
        end else if (READ_ENBLE) begin
            r_rd_q <= w_rd_data;
        end
    end

    generate
        if (MEMORY_LATENCY == LOW_LATENCY) begin : g_low
            assign DATA_OUT = r_rd_q;
        end else if (MEMORY_LATENCY == HIGH_LATENCY) begin : g_high
            logic [MEMORY_WIDTH-1:0] r_out_q;

            // Output register, loaded every edge regardless of the read strobe.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_out_q <= '0;
                end else begin
                    r_out_q <= r_rd_q;
                end
            end

            assign DATA_OUT = r_out_q;
        end else begin : g_bad_latency
            $error("dual_port_memory: MEMORY_LATENCY must be LOW_LATENCY or HIGH_LATENCY");
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_memory.sv
// Self-checking bench: three memory configurations driven from shared stimulus,
// compared every cycle against an array-based reference of the read/write rules.
module tb_dual_port_memory;

    logic        clk;
    logic        rst_n;
    logic [3:0]  waddr;
    logic [3:0]  raddr;
    logic [63:0] din;
    logic        we;
    logic        re;
    logic [7:0]  do_a;
    logic [63:0] do_b;
    logic [3:0]  do_c;

    int checks   = 0;
    int failures = 0;

    // Reference state: word arrays plus the value each port should present.
    logic [63:0] m_a [16];
    logic [63:0] m_b [16];
    logic [63:0] m_c [12];
    logic [63:0] exp_a;
    logic [63:0] exp_b_rd;
    logic [63:0] exp_b;
    logic [63:0] exp_c;

    dual_port_memory #(
        .MEMORY_WIDTH  (8),
        .MEMORY_DEPTH  (16),
        .MEMORY_LATENCY("LOW_LATENCY")
    ) u_low (
        .CLK          (clk),
        .RST_N        (rst_n),
        .WRITE_ADDRESS(waddr),
        .DATA_IN      (din[7:0]),
        .WRITE_ENABLE (we),
        .READ_ADDRESS (raddr),
        .READ_ENBLE   (re),
        .DATA_OUT     (do_a)
    );

    dual_port_memory #(
        .MEMORY_WIDTH  (64),
        .MEMORY_DEPTH  (16),
        .MEMORY_LATENCY("HIGH_LATENCY")
    ) u_high (
        .CLK          (clk),
        .RST_N        (rst_n),
        .WRITE_ADDRESS(waddr),
        .DATA_IN      (din),
        .WRITE_ENABLE (we),
        .READ_ADDRESS (raddr),
        .READ_ENBLE   (re),
        .DATA_OUT     (do_b)
    );

    dual_port_memory #(
        .MEMORY_WIDTH  (4),
        .MEMORY_DEPTH  (12),
        .MEMORY_LATENCY("LOW_LATENCY")
    ) u_npow2 (
        .CLK          (clk),
        .RST_N        (rst_n),
        .WRITE_ADDRESS(waddr),
        .DATA_IN      (din[3:0]),
        .WRITE_ENABLE (we),
        .READ_ADDRESS (raddr),
        .READ_ENBLE   (re),
        .DATA_OUT     (do_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_low"},  {56'd0, do_a}, exp_a);
        chk({tag, "_high"}, do_b,          exp_b);
        chk({tag, "_d12"},  {60'd0, do_c}, exp_c);
    endtask

    task automatic model_reset();
        exp_a    = '0;
        exp_b_rd = '0;
        exp_b    = '0;
        exp_c    = '0;
    endtask

    // One clock edge: apply the read-first/write rules to the model, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_b = exp_b_rd;
            if (re) begin
                exp_a    = m_a[raddr];
                exp_b_rd = m_b[raddr];
                exp_c    = (raddr < 12) ? m_c[raddr] : 64'd0;
            end
            if (we) begin
                m_a[waddr] = {56'd0, din[7:0]};
                m_b[waddr] = din;
                if (waddr < 12) m_c[waddr] = {60'd0, din[3:0]};
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic w, input int wa, input logic [63:0] d,
                         input logic r, input int ra);
        we    = w;
        waddr = 4'(wa);
        din   = d;
        re    = r;
        raddr = 4'(ra);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        for (int i = 0; i < 12; i++) m_c[i] = '0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 64'd0, 1'b0, 0);
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Write then read, low and high latency.
        drive(1'b1, 3, 64'h0123456789ABCDA5, 1'b0, 0);
        tick("wr3");
        drive(1'b0, 0, 64'd0, 1'b1, 3);
        tick("rd3");
        chk("low_a5", {56'd0, do_a}, 64'hA5);
        chk("high_not_yet", do_b, 64'd0);
        drive(1'b0, 0, 64'd0, 1'b0, 0);
        tick("rd3_n1");
        chk("high_2edge", do_b, 64'h0123456789ABCDA5);

        // Same-edge write and read of address 5: read-first.
        drive(1'b1, 5, 64'h11, 1'b0, 0);
        tick("wr5_old");
        drive(1'b1, 5, 64'h22, 1'b1, 5);
        tick("rdw5");
        chk("rdw_old", {56'd0, do_a}, 64'h11);
        drive(1'b0, 0, 64'd0, 1'b1, 5);
        tick("rd5_new");
        chk("rdw_new", {56'd0, do_a}, 64'h22);

        // Read-enable low holds the last result.
        drive(1'b1, 2, 64'h3C, 1'b0, 0);
        tick("wr2");
        drive(1'b0, 0, 64'd0, 1'b1, 2);
        tick("rd2");
        drive(1'b0, 0, 64'd0, 1'b0, 4);
        tick("hold1");
        tick("hold2");
        chk("hold_3c", {56'd0, do_a}, 64'h3C);

        // Asynchronous reset mid-cycle; memory survives, writes blocked.
        drive(1'b1, 2, 64'h5A, 1'b0, 0);
        tick("wr2_5a");
        drive(1'b0, 0, 64'd0, 1'b1, 2);
        tick("rd2_5a");
        chk("pre_rst_5a", {56'd0, do_a}, 64'h5A);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        drive(1'b1, 2, 64'h77, 1'b1, 2);
        tick("in_rst");
        #3;
        rst_n = 1'b1;
        drive(1'b0, 0, 64'd0, 1'b1, 2);
        tick("post_rst");
        chk("mem_kept", {56'd0, do_a}, 64'h5A);

        // Non-power-of-two depth: address 13 out of range.
        drive(1'b1, 13, 64'hF, 1'b0, 0);
        tick("wr13");
        drive(1'b0, 0, 64'd0, 1'b1, 13);
        tick("rd13");
        chk("d12_oor", {60'd0, do_c}, 64'd0);

        // Pipelined reads of consecutive addresses.
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, a, 64'(a + 9), 1'b0, 0);
            tick("pwr");
        end
        for (int a = 0; a < 3; a++) begin
            drive(1'b0, 0, 64'd0, 1'b1, a);
            tick("prd");
            chk("pipe_d12", {60'd0, do_c}, 64'(a + 9));
        end

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom), int'($urandom_range(0, 15)),
                  {$urandom, $urandom}, 1'($urandom), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) begin
                #3;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                tick("rand_in_rst");
                #3;
                rst_n = 1'b1;
            end else begin
                tick("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
